// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter/sequencer in front of a 1024x32 single-port RAM
// (registered address, unregistered q). Define FIXED_PRIO_EN for fixed m0-wins priority.
`timescale 1ns/1ps

module onchip_mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int BE_W    = 4,
    parameter bit RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              freeze_req,
    output logic              idle,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              mem_clken
);

    typedef enum logic {
        MASTER_0 = 1'b0,
        MASTER_1 = 1'b1
    } master_e;

    logic              req0;
    logic              req1;
    master_e           sel;
    logic              grant_any;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_address;
    logic [BE_W-1:0]   sel_byteenable;
    logic [DATA_W-1:0] sel_writedata;

    logic              rd_pend;
    master_e           rd_owner;
    logic [ADDR_W-1:0] last_address;
    logic [BE_W-1:0]   last_byteenable;
    logic [DATA_W-1:0] last_writedata;

    // A simultaneous read+write from one master is treated as a write.
    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef FIXED_PRIO_EN
    always_comb begin
        sel = req0 ? MASTER_0 : MASTER_1;
    end
`else
    master_e prio;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel = prio;
        if (req0 && !req1) begin
            sel = MASTER_0;
        end else if (req1 && !req0) begin
            sel = MASTER_1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio <= master_e'(RR_INIT);
        end else if (grant_any) begin
            prio <= (sel == MASTER_0) ? MASTER_1 : MASTER_0;
        end
    end
`endif

    assign grant_any = ~freeze_req & (req0 | req1);

    assign m0_waitrequest = ~(grant_any && sel == MASTER_0);
    assign m1_waitrequest = ~(grant_any && sel == MASTER_1);

    always_comb begin
        sel_write      = m0_write;
        sel_address    = m0_address;
        sel_byteenable = m0_byteenable;
        sel_writedata  = m0_writedata;
        if (sel == MASTER_1) begin
            sel_write      = m1_write;
            sel_address    = m1_address;
            sel_byteenable = m1_byteenable;
            sel_writedata  = m1_writedata;
        end
    end

    // The RAM registers its address itself, so the issued access is driven combinationally
    // in the grant cycle; idle cycles replay the last address/data to keep the pins quiet.
    assign mem_chipselect = grant_any;
    assign mem_write      = grant_any & sel_write;
    assign mem_address    = grant_any ? sel_address    : last_address;
    assign mem_byteenable = grant_any ? sel_byteenable : last_byteenable;
    assign mem_writedata  = grant_any ? sel_writedata  : last_writedata;
    assign mem_clken      = 1'b1;

    // NOTE: pure datapath hold registers carry no reset; chipselect gates them until first use.
    always_ff @(posedge clk) begin
        if (grant_any) begin
            last_address    <= sel_address;
            last_byteenable <= sel_byteenable;
            last_writedata  <= sel_writedata;
        end
    end

    // Read return: q appears the cycle after the RAM samples the address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= MASTER_0;
        end else begin
            rd_pend  <= grant_any & ~sel_write;
            rd_owner <= sel;
        end
    end

    assign m0_readdatavalid = rd_pend && rd_owner == MASTER_0;
    assign m1_readdatavalid = rd_pend && rd_owner == MASTER_1;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

    assign idle = freeze_req & ~rd_pend;

`ifndef SYNTHESIS
    a_m0_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(m0_read && m0_write));
    a_m1_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(m1_read && m1_write));
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model with a shadow memory.
`timescale 1ns/1ps

module tb_onchip_mem_arbiter;

`ifdef FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif
    localparam bit RR_INIT = 1'b0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        freeze_req;
    logic        idle;
    logic [9:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .BE_W(4), .RR_INIT(RR_INIT)) dut (
        .clk(clk), .reset_n(reset_n), .freeze_req(freeze_req), .idle(idle),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_clken(mem_clken)
    );

    // RAM stand-in: registered address, byte-enabled write, unregistered q.
    logic [31:0] ram [1024];
    logic [9:0]  ram_addr_q = '0;
    always @(posedge clk) begin
        if (mem_clken) begin
            if (mem_chipselect && mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            ram_addr_q <= mem_address;
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_reqs();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    task automatic drive_m0(input logic rd, input logic wr, input logic [9:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    endtask

    task automatic drive_m1(input logic rd, input logic wr, input logic [9:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0; freeze_req = 0; clear_reqs();
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++; if (m0_waitrequest !== 1'b1) begin tests_failed++;
            $display("FAIL reset_m0_wait: got %b want 1", m0_waitrequest); end
        tests_run++; if (m1_waitrequest !== 1'b1) begin tests_failed++;
            $display("FAIL reset_m1_wait: got %b want 1", m1_waitrequest); end
        tests_run++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin tests_failed++;
            $display("FAIL reset_rdv: got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
        tests_run++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin tests_failed++;
            $display("FAIL reset_mem_cs: got cs=%b we=%b want 0 0", mem_chipselect, mem_write); end
        tests_run++; if (idle !== 1'b0) begin tests_failed++;
            $display("FAIL reset_idle: got %b want 0", idle); end
        tests_run++; if (mem_clken !== 1'b1) begin tests_failed++;
            $display("FAIL reset_clken: got %b want 1", mem_clken); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        drive_m0(0, 1, 10'h005, 32'hDEADBEEF, 4'hF);
        #1;
        tests_run++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin tests_failed++;
            $display("FAIL wr_grant: got w0=%b w1=%b want 0 1", m0_waitrequest, m1_waitrequest); end
        tests_run++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b1 || mem_address !== 10'h005) begin
            tests_failed++;
            $display("FAIL wr_issue: got cs=%b we=%b a=%h want 1 1 005", mem_chipselect, mem_write, mem_address); end
        @(negedge clk);
        clear_reqs();
        drive_m1(1, 0, 10'h005, 32'h0, 4'h0);
        #1;
        tests_run++; if (m1_waitrequest !== 1'b0) begin tests_failed++;
            $display("FAIL rd_grant: got m1_wait=%b want 0", m1_waitrequest); end
        tests_run++; if (m0_readdatavalid !== 1'b0) begin tests_failed++;
            $display("FAIL wr_no_rdv: got m0_rdv=%b want 0", m0_readdatavalid); end
        @(negedge clk);
        clear_reqs();
        #1;
        tests_run++; if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0) begin tests_failed++;
            $display("FAIL rd_rdv: got m0=%b m1=%b want 0 1", m0_readdatavalid, m1_readdatavalid); end
        tests_run++; if (m1_readdata !== 32'hDEADBEEF) begin tests_failed++;
            $display("FAIL rd_data: got %h want deadbeef", m1_readdata); end
    endtask

    task automatic test_be_wrap();
        @(negedge clk);
        drive_m0(0, 1, 10'h3FF, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        drive_m0(0, 1, 10'h3FF, 32'h12345678, 4'h3);
        @(negedge clk);
        drive_m0(1, 0, 10'h3FF, 32'h0, 4'h0);
        #1;
        tests_run++; if (m0_waitrequest !== 1'b0) begin tests_failed++;
            $display("FAIL be_rd_grant: got %b want 0", m0_waitrequest); end
        @(negedge clk);
        clear_reqs();
        #1;
        tests_run++; if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0) begin tests_failed++;
            $display("FAIL be_rdv: got m0=%b m1=%b want 1 0", m0_readdatavalid, m1_readdatavalid); end
        tests_run++; if (m0_readdata !== 32'hFFFF5678 || m1_readdata !== 32'hFFFF5678) begin tests_failed++;
            $display("FAIL be_data: got %h/%h want ffff5678", m0_readdata, m1_readdata); end
    endtask

    task automatic test_contention();
        int exp_g [4];
        for (int k = 0; k < 4; k++) exp_g[k] = FIXED_PRIO ? 0 : (k % 2);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) begin
                drive_m0(1, 0, 10'h010, 32'h0, 4'h0);
                drive_m1(1, 0, 10'h020, 32'h0, 4'h0);
            end else begin
                clear_reqs();
            end
            #1;
            if (k < 4) begin
                tests_run++;
                if (m0_waitrequest !== (exp_g[k] != 0) || m1_waitrequest !== (exp_g[k] != 1)) begin
                    tests_failed++;
                    $display("FAIL contend_grant[%0d]: got w0=%b w1=%b want master %0d", k,
                             m0_waitrequest, m1_waitrequest, exp_g[k]);
                end
            end
            if (k > 0) begin
                tests_run++;
                if (m0_readdatavalid !== (exp_g[k-1] == 0) || m1_readdatavalid !== (exp_g[k-1] == 1)) begin
                    tests_failed++;
                    $display("FAIL contend_rdv[%0d]: got m0=%b m1=%b want master %0d", k,
                             m0_readdatavalid, m1_readdatavalid, exp_g[k-1]);
                end
            end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        @(negedge clk);
        drive_m1(1, 0, 10'h005, 32'h0, 4'h0);
        #1;
        tests_run++; if (m1_waitrequest !== 1'b0) begin tests_failed++;
            $display("FAIL frz_pre_grant: got %b want 0", m1_waitrequest); end
        @(negedge clk);
        freeze_req = 1;
        drive_m0(1, 0, 10'h005, 32'h0, 4'h0);
        #1;
        tests_run++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin tests_failed++;
            $display("FAIL frz_wait: got w0=%b w1=%b want 1 1", m0_waitrequest, m1_waitrequest); end
        tests_run++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hDEADBEEF) begin tests_failed++;
            $display("FAIL frz_inflight: got rdv=%b d=%h want 1 deadbeef", m1_readdatavalid, m1_readdata); end
        tests_run++; if (idle !== 1'b0) begin tests_failed++;
            $display("FAIL frz_idle_busy: got %b want 0", idle); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (idle !== 1'b1 || mem_chipselect !== 1'b0 || m0_waitrequest !== 1'b1 ||
                m1_waitrequest !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
                tests_failed++;
                $display("FAIL frz_hold[%0d]: got idle=%b cs=%b w=%b%b rdv=%b%b want 1 0 11 00", k, idle,
                         mem_chipselect, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid);
            end
        end
        @(negedge clk);
        freeze_req = 0;
        #1;
        tests_run++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1 || idle !== 1'b0) begin
            tests_failed++;
            $display("FAIL frz_resume: got w0=%b w1=%b idle=%b want 0 1 0", m0_waitrequest, m1_waitrequest, idle); end
        @(negedge clk);
        clear_reqs();
        #1;
        tests_run++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF) begin tests_failed++;
            $display("FAIL frz_post_rd: got rdv=%b d=%h want 1 deadbeef", m0_readdatavalid, m0_readdata); end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        @(negedge clk);
        drive_m0(1, 0, 10'h005, 32'h0, 4'h0);
        #1;
        tests_run++; if (m0_waitrequest !== 1'b0) begin tests_failed++;
            $display("FAIL rst_rd_grant: got %b want 0", m0_waitrequest); end
        @(negedge clk);
        clear_reqs();
        reset_n = 0;
        #1;
        tests_run++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin tests_failed++;
            $display("FAIL rst_drop_rdv: got m0=%b m1=%b want 0 0", m0_readdatavalid, m1_readdatavalid); end
        @(negedge clk);
        reset_n = 1;
        #1;
        tests_run++;
        if (m0_readdatavalid !== 1'b0 || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 ||
            mem_chipselect !== 1'b0 || idle !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_release: got rdv=%b w=%b%b cs=%b idle=%b want 0 11 0 0", m0_readdatavalid,
                     m0_waitrequest, m1_waitrequest, mem_chipselect, idle);
        end
        @(negedge clk);
        drive_m0(1, 0, 10'h005, 32'h0, 4'h0);
        drive_m1(1, 0, 10'h005, 32'h0, 4'h0);
        #1;
        tests_run++; if (m0_waitrequest !== RR_INIT || m1_waitrequest !== ~RR_INIT) begin tests_failed++;
            $display("FAIL rst_prio: got w0=%b w1=%b want %b %b", m0_waitrequest, m1_waitrequest,
                     RR_INIT, ~RR_INIT); end
        @(negedge clk);
        clear_reqs();
        #1;
        tests_run++; if (m0_readdatavalid !== 1'b1) begin tests_failed++;
            $display("FAIL rst_post_rdv: got %b want 1", m0_readdatavalid); end
    endtask

    typedef struct {
        bit          active;
        bit          is_wr;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } op_t;

    task automatic test_random();
        logic [31:0] ref_mem [1024];
        op_t         op [2];
        int          turn;
        bit          pend_v;
        int          pend_o;
        logic [31:0] pend_d;
        int          win;
        int          n_warm;
        do_reset();
        turn = RR_INIT; pend_v = 0; pend_o = 0; pend_d = '0;
        n_warm = 16;
        op[0].active = 0; op[1].active = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            // Warm-up fills the 16-word window through m0 so later reads have known contents.
            if (cyc < n_warm) begin
                op[0] = '{1, 1, 10'h100 + 10'(cyc), $urandom, 4'hF};
                op[1].active = 0;
                freeze_req = 0;
            end else begin
                for (int m = 0; m < 2; m++) begin
                    if (!op[m].active && ($urandom_range(0, 9) < 6)) begin
                        op[m].active = 1;
                        op[m].is_wr  = $urandom_range(0, 2) == 0;
                        op[m].addr   = 10'h100 + 10'($urandom_range(0, 15));
                        op[m].data   = $urandom;
                        op[m].be     = 4'($urandom_range(1, 15));
                    end
                end
                freeze_req = $urandom_range(0, 9) == 0;
            end
            drive_m0(op[0].active && !op[0].is_wr, op[0].active && op[0].is_wr,
                     op[0].addr, op[0].data, op[0].be);
            drive_m1(op[1].active && !op[1].is_wr, op[1].active && op[1].is_wr,
                     op[1].addr, op[1].data, op[1].be);
            #1;
            if (freeze_req)                        win = -1;
            else if (op[0].active && op[1].active) win = FIXED_PRIO ? 0 : turn;
            else if (op[0].active)                 win = 0;
            else if (op[1].active)                 win = 1;
            else                                   win = -1;

            tests_run++;
            if (m0_waitrequest !== (win != 0) || m1_waitrequest !== (win != 1) ||
                mem_chipselect !== (win >= 0)) begin
                tests_failed++;
                $display("FAIL rand_grant[%0d]: got w=%b%b cs=%b want winner %0d", cyc,
                         m0_waitrequest, m1_waitrequest, mem_chipselect, win);
            end
            tests_run++;
            if (m0_readdatavalid !== (pend_v && pend_o == 0) || m1_readdatavalid !== (pend_v && pend_o == 1) ||
                idle !== (freeze_req && !pend_v)) begin
                tests_failed++;
                $display("FAIL rand_rdv[%0d]: got rdv=%b%b idle=%b want pend=%0d owner=%0d", cyc,
                         m0_readdatavalid, m1_readdatavalid, idle, pend_v, pend_o);
            end
            if (pend_v) begin
                tests_run++;
                if ((pend_o == 0 ? m0_readdata : m1_readdata) !== pend_d) begin
                    tests_failed++;
                    $display("FAIL rand_data[%0d]: got %h want %h", cyc,
                             (pend_o == 0 ? m0_readdata : m1_readdata), pend_d);
                end
            end

            pend_v = 0;
            if (win >= 0) begin
                if (op[win].is_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (op[win].be[b]) ref_mem[op[win].addr][8*b +: 8] = op[win].data[8*b +: 8];
                end else begin
                    pend_v = 1;
                    pend_o = win;
                    pend_d = ref_mem[op[win].addr];
                end
                turn = 1 - win;
                op[win].active = 0;
            end
        end
        @(negedge clk);
        clear_reqs();
        freeze_req = 0;
    endtask

    initial begin
        reset_n = 0; freeze_req = 0; clear_reqs();
        drive_m0(0, 0, '0, '0, '0);
        drive_m1(0, 0, '0, '0, '0);
        test_reset();
        test_write_read();
        test_be_wrap();
        test_contention();
        test_freeze();
        test_reset_mid_read();
        test_random();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
